// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatcher, CDB and commit-side signals of the reorder buffer
interface reorder_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int RoB_WIDTH  = 4
);
   logic                  DPRoB_en;
   logic [1:0]            DPRoB_type;
   logic [REG_WIDTH-1:0]  DPRoB_rd;
   logic [ADDR_WIDTH-1:0] DPRoB_pred_pc;
   logic                  RoBDP_full;
   logic [RoB_WIDTH-1:0]  RoBDP_tail;
   logic [RoB_WIDTH-1:0]  DPRoB_qj, DPRoB_qk;
   logic                  RoBDP_qj_ready, RoBDP_qk_ready;
   logic [31:0]           RoBDP_qj_value, RoBDP_qk_value;
   logic                  CDBRoB_RS_en;
   logic [RoB_WIDTH-1:0]  CDBRoB_RS_RoB_index;
   logic [31:0]           CDBRoB_RS_value;
   logic [ADDR_WIDTH-1:0] CDBRoB_RS_next_pc;
   logic                  CDBRoB_LSB_en;
   logic [RoB_WIDTH-1:0]  CDBRoB_LSB_RoB_index;
   logic [31:0]           CDBRoB_LSB_value;
   logic                  RoBRF_en;
   logic [REG_WIDTH-1:0]  RoBRF_rd;
   logic [31:0]           RoBRF_value;
   logic [RoB_WIDTH-1:0]  RoBRF_index;
   logic                  RoBLSB_commit_en;
   logic [RoB_WIDTH-1:0]  RoBLSB_commit_index;
   logic                  RoB_clear;
   logic [ADDR_WIDTH-1:0] RoBIF_new_pc;

   modport master (
      output DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_pc, DPRoB_qj, DPRoB_qk,
             CDBRoB_RS_en, CDBRoB_RS_RoB_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
             CDBRoB_LSB_en, CDBRoB_LSB_RoB_index, CDBRoB_LSB_value,
      input  RoBDP_full, RoBDP_tail, RoBDP_qj_ready, RoBDP_qk_ready, RoBDP_qj_value, RoBDP_qk_value,
             RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_index, RoBLSB_commit_en, RoBLSB_commit_index,
             RoB_clear, RoBIF_new_pc
   );

   modport slave (
      input  DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pred_pc, DPRoB_qj, DPRoB_qk,
             CDBRoB_RS_en, CDBRoB_RS_RoB_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
             CDBRoB_LSB_en, CDBRoB_LSB_RoB_index, CDBRoB_LSB_value,
      output RoBDP_full, RoBDP_tail, RoBDP_qj_ready, RoBDP_qk_ready, RoBDP_qj_value, RoBDP_qk_value,
             RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_index, RoBLSB_commit_en, RoBLSB_commit_index,
             RoB_clear, RoBIF_new_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order-commit buffer with CDB writeback, operand forwarding and mispredict flush
module reorder_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int RoB_WIDTH  = 4
) (
   input logic             clk_in,
   input logic             rst_in,
   input logic             rdy_in,
   reorder_buffer_if.slave rob
);
   localparam int RoB_SIZE = 1 << RoB_WIDTH;
   localparam logic [RoB_WIDTH:0] FULL_CNT = RoB_SIZE;
   localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_JALR = 2'd3;
   logic [RoB_SIZE-1:0]   busy_q, ready_q;
   logic [1:0]            type_q  [RoB_SIZE];
   logic [REG_WIDTH-1:0]  rd_q    [RoB_SIZE];
   logic [ADDR_WIDTH-1:0] pred_q  [RoB_SIZE];
   logic [ADDR_WIDTH-1:0] npc_q   [RoB_SIZE];
   logic [31:0]           value_q [RoB_SIZE];
   logic [RoB_WIDTH-1:0]  head, tail, rf_index, lsb_index;
   logic [RoB_WIDTH:0]    count;
   logic [REG_WIDTH-1:0]  rf_rd;
   logic [31:0]           rf_value;
   logic [ADDR_WIDTH-1:0] new_pc;
   logic                  rf_en, lsb_en, clear;
   logic                  full, do_issue, do_commit, is_rf, mispred, rs_wb, lsb_wb;
   logic [1:0]            h_type;

   // CDB hits on the looked-up entry win over stored state; RS before LSB
   function automatic logic [32:0] lookup(input logic [RoB_WIDTH-1:0] idx);
      return (rob.CDBRoB_RS_en && rob.CDBRoB_RS_RoB_index == idx) ? {1'b1, rob.CDBRoB_RS_value} :
             (rob.CDBRoB_LSB_en && rob.CDBRoB_LSB_RoB_index == idx) ? {1'b1, rob.CDBRoB_LSB_value} :
             {ready_q[idx], value_q[idx]};
   endfunction

   always_comb begin
      full      = count == FULL_CNT;
      h_type    = type_q[head];
      do_issue  = rdy_in && rob.DPRoB_en && !full;
      do_commit = rdy_in && count != '0 && ready_q[head];
      is_rf     = h_type == T_REG || h_type == T_JALR;
      mispred   = do_commit && h_type[1] && npc_q[head] != pred_q[head];
      rs_wb     = rdy_in && !clear && rob.CDBRoB_RS_en && busy_q[rob.CDBRoB_RS_RoB_index];
      lsb_wb    = rdy_in && !clear && rob.CDBRoB_LSB_en && busy_q[rob.CDBRoB_LSB_RoB_index];
   end

   assign rob.RoBDP_full = full;
   assign rob.RoBDP_tail = tail;
   assign {rob.RoBDP_qj_ready, rob.RoBDP_qj_value} = lookup(rob.DPRoB_qj);
   assign {rob.RoBDP_qk_ready, rob.RoBDP_qk_value} = lookup(rob.DPRoB_qk);
   assign rob.RoBRF_en = rf_en;
   assign rob.RoBRF_rd = rf_rd;
   assign rob.RoBRF_value = rf_value;
   assign rob.RoBRF_index = rf_index;
   assign rob.RoBLSB_commit_en = lsb_en;
   assign rob.RoBLSB_commit_index = lsb_index;
   assign rob.RoB_clear = clear;
   assign rob.RoBIF_new_pc = new_pc;

   always_ff @(posedge clk_in) begin
      if (rs_wb) begin
         value_q[rob.CDBRoB_RS_RoB_index] <= rob.CDBRoB_RS_value;
         npc_q[rob.CDBRoB_RS_RoB_index]   <= rob.CDBRoB_RS_next_pc;
      end
      if (lsb_wb) value_q[rob.CDBRoB_LSB_RoB_index] <= rob.CDBRoB_LSB_value;
      if (do_issue) begin
         type_q[tail] <= rob.DPRoB_type;
         rd_q[tail]   <= rob.DPRoB_rd;
         pred_q[tail] <= rob.DPRoB_pred_pc;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         busy_q    <= '0;
         ready_q   <= '0;
         rf_en     <= 1'b0;
         rf_rd     <= '0;
         rf_value  <= '0;
         rf_index  <= '0;
         lsb_en    <= 1'b0;
         lsb_index <= '0;
         clear     <= 1'b0;
         new_pc    <= '0;
      end else begin
         rf_en  <= 1'b0;
         lsb_en <= 1'b0;
         clear  <= 1'b0;
         if (rs_wb) ready_q[rob.CDBRoB_RS_RoB_index] <= 1'b1;
         if (lsb_wb) ready_q[rob.CDBRoB_LSB_RoB_index] <= 1'b1;
         if (do_issue) begin
            busy_q[tail]  <= 1'b1;
            ready_q[tail] <= 1'b0;
            tail          <= tail + 1'b1;
         end
         if (do_commit) begin
            busy_q[head]  <= 1'b0;
            ready_q[head] <= 1'b0;
            head          <= head + 1'b1;
            rf_en         <= is_rf;
            lsb_en        <= h_type == T_STORE;
            if (is_rf) begin
               rf_rd    <= rd_q[head];
               rf_value <= value_q[head];
               rf_index <= head;
            end
            if (h_type == T_STORE) lsb_index <= head;
         end
         count <= (do_issue && !do_commit) ? count + 1'b1 :
                  (!do_issue && do_commit) ? count - 1'b1 : count;
         // flush overrides any same-cycle issue or writeback
         if (mispred) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            busy_q  <= '0;
            ready_q <= '0;
            clear   <= 1'b1;
            new_pc  <= npc_q[head];
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus a randomized run checked against a queue-based model
module tb_reorder_buffer;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b0;
   int   total = 0;
   int   passed = 0;

   reorder_buffer_if bus ();
   reorder_buffer dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob(bus.slave));

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [1:0]  t;
      logic [4:0]  rd;
      logic [31:0] pred;
      logic [31:0] val;
      logic [31:0] npc;
      bit          rdy;
      logic [3:0]  idx;
   } ent_t;
   ent_t q[$];

   task automatic idle();
      bus.DPRoB_en = 0; bus.DPRoB_type = 0; bus.DPRoB_rd = 0; bus.DPRoB_pred_pc = 0;
      bus.DPRoB_qj = 0; bus.DPRoB_qk = 0;
      bus.CDBRoB_RS_en = 0; bus.CDBRoB_RS_RoB_index = 0; bus.CDBRoB_RS_value = 0; bus.CDBRoB_RS_next_pc = 0;
      bus.CDBRoB_LSB_en = 0; bus.CDBRoB_LSB_RoB_index = 0; bus.CDBRoB_LSB_value = 0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rdy_in = 1;
      rst_in = 0;
      #7;
      rst_in = 1;
      tick();
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pred);
      bus.DPRoB_en = 1; bus.DPRoB_type = t; bus.DPRoB_rd = rd; bus.DPRoB_pred_pc = pred;
      tick();
      bus.DPRoB_en = 0;
   endtask

   task automatic rs_write(input logic [3:0] idx, input logic [31:0] val, input logic [31:0] npc);
      bus.CDBRoB_RS_en = 1; bus.CDBRoB_RS_RoB_index = idx; bus.CDBRoB_RS_value = val; bus.CDBRoB_RS_next_pc = npc;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus.RoBDP_tail, bus.RoBDP_full, bus.RoBRF_en, bus.RoBLSB_commit_en, bus.RoB_clear, bus.RoBIF_new_pc} !== '0)
         $display("FAIL reset_state got tail=%0d full=%b rf=%b lsb=%b clr=%b pc=%h want all 0",
                  bus.RoBDP_tail, bus.RoBDP_full, bus.RoBRF_en, bus.RoBLSB_commit_en, bus.RoB_clear, bus.RoBIF_new_pc);
      else passed++;
      for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 32'h0);
      rs_write(4'd0, 32'h55, 32'h0);
      issue(2'd0, 5'd9, 32'h0);
      idle();
      tick();
      total++;
      if ({bus.RoBRF_en, bus.RoBDP_tail} !== {1'b1, 4'd5})
         $display("FAIL pre_reset got rf_en=%b tail=%0d want 1 5", bus.RoBRF_en, bus.RoBDP_tail);
      else passed++;
      #2 rst_in = 0;
      #1;
      total++;
      if ({bus.RoBDP_tail, bus.RoBDP_full, bus.RoBRF_en, bus.RoBRF_value, bus.RoBRF_rd} !== '0)
         $display("FAIL async_reset got tail=%0d full=%b rf_en=%b value=%h rd=%0d want 0",
                  bus.RoBDP_tail, bus.RoBDP_full, bus.RoBRF_en, bus.RoBRF_value, bus.RoBRF_rd);
      else passed++;
      #2 rst_in = 1;
   endtask

   task automatic test_single_commit();
      do_reset();
      issue(2'd0, 5'd3, 32'h0);
      rs_write(4'd0, 32'h1234, 32'h0);
      tick();
      idle();
      total++;
      if (bus.RoBRF_en !== 1'b0) $display("FAIL commit_too_early got %b want 0", bus.RoBRF_en);
      else passed++;
      tick();
      total++;
      if ({bus.RoBRF_en, bus.RoBRF_rd, bus.RoBRF_value, bus.RoBRF_index} !== {1'b1, 5'd3, 32'h1234, 4'd0})
         $display("FAIL single_commit got en=%b rd=%0d val=%h idx=%0d want 1 3 1234 0",
                  bus.RoBRF_en, bus.RoBRF_rd, bus.RoBRF_value, bus.RoBRF_index);
      else passed++;
      tick();
      total++;
      if (bus.RoBRF_en !== 1'b0) $display("FAIL commit_pulse got %b want 0", bus.RoBRF_en);
      else passed++;
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 16; i++) issue(2'd0, 5'(i), 32'h0);
      total++;
      if ({bus.RoBDP_full, bus.RoBDP_tail} !== {1'b1, 4'd0})
         $display("FAIL full_after_16 got full=%b tail=%0d want 1 0", bus.RoBDP_full, bus.RoBDP_tail);
      else passed++;
      bus.DPRoB_en = 1; bus.DPRoB_rd = 5'd20;
      tick();
      total++;
      if ({bus.RoBDP_full, bus.RoBDP_tail} !== {1'b1, 4'd0})
         $display("FAIL issue_when_full got full=%b tail=%0d want 1 0", bus.RoBDP_full, bus.RoBDP_tail);
      else passed++;
      rs_write(4'd0, 32'h77, 32'h0);
      tick();
      bus.CDBRoB_RS_en = 0;
      tick();
      total++;
      if ({bus.RoBRF_en, bus.RoBRF_index, bus.RoBDP_full, bus.RoBDP_tail} !== {1'b1, 4'd0, 1'b0, 4'd0})
         $display("FAIL commit_frees got rf_en=%b idx=%0d full=%b tail=%0d want 1 0 0 0",
                  bus.RoBRF_en, bus.RoBRF_index, bus.RoBDP_full, bus.RoBDP_tail);
      else passed++;
      tick();
      idle();
      total++;
      if ({bus.RoBDP_full, bus.RoBDP_tail} !== {1'b1, 4'd1})
         $display("FAIL wrap_issue got full=%b tail=%0d want 1 1", bus.RoBDP_full, bus.RoBDP_tail);
      else passed++;
   endtask

   task automatic test_out_of_order();
      do_reset();
      issue(2'd0, 5'd1, 32'h0);
      issue(2'd0, 5'd2, 32'h0);
      rs_write(4'd1, 32'h11, 32'h0);
      tick();
      idle();
      tick();
      total++;
      if (bus.RoBRF_en !== 1'b0) $display("FAIL ooo_no_commit got %b want 0", bus.RoBRF_en);
      else passed++;
      rs_write(4'd0, 32'h10, 32'h0);
      tick();
      idle();
      tick();
      total++;
      if ({bus.RoBRF_en, bus.RoBRF_index, bus.RoBRF_value} !== {1'b1, 4'd0, 32'h10})
         $display("FAIL ooo_first got en=%b idx=%0d val=%h want 1 0 10", bus.RoBRF_en, bus.RoBRF_index, bus.RoBRF_value);
      else passed++;
      tick();
      total++;
      if ({bus.RoBRF_en, bus.RoBRF_index, bus.RoBRF_value} !== {1'b1, 4'd1, 32'h11})
         $display("FAIL ooo_second got en=%b idx=%0d val=%h want 1 1 11", bus.RoBRF_en, bus.RoBRF_index, bus.RoBRF_value);
      else passed++;
      tick();
      total++;
      if (bus.RoBRF_en !== 1'b0) $display("FAIL ooo_end got %b want 0", bus.RoBRF_en);
      else passed++;
   endtask

   task automatic test_forwarding();
      do_reset();
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 1), 32'h0);
      bus.DPRoB_qj = 4'd2; bus.DPRoB_qk = 4'd2;
      #1;
      total++;
      if (bus.RoBDP_qk_ready !== 1'b0) $display("FAIL lookup_not_ready got %b want 0", bus.RoBDP_qk_ready);
      else passed++;
      bus.CDBRoB_LSB_en = 1; bus.CDBRoB_LSB_RoB_index = 4'd2; bus.CDBRoB_LSB_value = 32'hdead;
      #1;
      total++;
      if ({bus.RoBDP_qj_ready, bus.RoBDP_qj_value} !== {1'b1, 32'hdead})
         $display("FAIL fwd_lsb got rdy=%b val=%h want 1 dead", bus.RoBDP_qj_ready, bus.RoBDP_qj_value);
      else passed++;
      rs_write(4'd2, 32'hbeef, 32'h0);
      #1;
      total++;
      if ({bus.RoBDP_qj_ready, bus.RoBDP_qj_value} !== {1'b1, 32'hbeef})
         $display("FAIL fwd_rs_priority got rdy=%b val=%h want 1 beef", bus.RoBDP_qj_ready, bus.RoBDP_qj_value);
      else passed++;
      bus.CDBRoB_RS_en = 0;
      tick();
      bus.CDBRoB_LSB_en = 0;
      #1;
      total++;
      if ({bus.RoBDP_qk_ready, bus.RoBDP_qk_value} !== {1'b1, 32'hdead})
         $display("FAIL stored_value got rdy=%b val=%h want 1 dead", bus.RoBDP_qk_ready, bus.RoBDP_qk_value);
      else passed++;
   endtask

   task automatic test_mispredict();
      do_reset();
      issue(2'd2, 5'd0, 32'h104);
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 4), 32'h0);
      rs_write(4'd1, 32'h1, 32'h0);
      tick();
      rs_write(4'd2, 32'h2, 32'h0);
      bus.CDBRoB_LSB_en = 1; bus.CDBRoB_LSB_RoB_index = 4'd3; bus.CDBRoB_LSB_value = 32'h3;
      tick();
      idle();
      rs_write(4'd0, 32'h0, 32'h200);
      tick();
      idle();
      bus.DPRoB_en = 1; bus.DPRoB_rd = 5'd9;
      tick();
      bus.DPRoB_en = 0;
      total++;
      if ({bus.RoB_clear, bus.RoBIF_new_pc, bus.RoBRF_en, bus.RoBDP_tail, bus.RoBDP_full} !== {1'b1, 32'h200, 1'b0, 4'd0, 1'b0})
         $display("FAIL mispredict got clr=%b pc=%h rf=%b tail=%0d full=%b want 1 200 0 0 0",
                  bus.RoB_clear, bus.RoBIF_new_pc, bus.RoBRF_en, bus.RoBDP_tail, bus.RoBDP_full);
      else passed++;
      tick();
      total++;
      if ({bus.RoB_clear, bus.RoBRF_en, bus.RoBDP_tail} !== {1'b0, 1'b0, 4'd0})
         $display("FAIL after_flush got clr=%b rf=%b tail=%0d want 0 0 0", bus.RoB_clear, bus.RoBRF_en, bus.RoBDP_tail);
      else passed++;
      tick();
      total++;
      if (bus.RoBRF_en !== 1'b0) $display("FAIL younger_commit got %b want 0", bus.RoBRF_en);
      else passed++;
   endtask

   task automatic test_random();
      logic [3:0]  m_tail = 0;
      logic        e_rf_en = 0, e_lsb_en = 0, e_clear = 0;
      logic [4:0]  e_rd = 0;
      logic [31:0] e_val = 0, e_npc = 0;
      logic [3:0]  e_rfi = 0, e_lsbi = 0;
      do_reset();
      q.delete();
      for (int c = 0; c < 800; c++) begin
         int pend[$];
         int rs_pos = -1, lsb_pos = -1;
         bit full, commit, mis;
         ent_t h;
         logic [32:0] exp_j, exp_k;
         idle();
         rdy_in = ($urandom_range(9) != 0);
         if ($urandom_range(2) != 0) begin
            bus.DPRoB_en = 1; bus.DPRoB_type = 2'($urandom_range(3));
            bus.DPRoB_rd = 5'($urandom); bus.DPRoB_pred_pc = $urandom;
         end
         foreach (q[i]) if (!q[i].rdy) pend.push_back(i);
         if (pend.size() > 0 && $urandom_range(1) == 1) begin
            int r = $urandom_range(pend.size() - 1);
            rs_pos = pend[r];
            pend.delete(r);
            rs_write(q[rs_pos].idx, $urandom,
                     (q[rs_pos].t[1] && $urandom_range(3) == 0) ? q[rs_pos].pred + 8 : q[rs_pos].pred);
         end
         foreach (pend[i]) if (lsb_pos < 0 && !q[pend[i]].t[1] && $urandom_range(2) == 0) lsb_pos = pend[i];
         if (lsb_pos >= 0) begin
            bus.CDBRoB_LSB_en = 1; bus.CDBRoB_LSB_RoB_index = q[lsb_pos].idx; bus.CDBRoB_LSB_value = $urandom;
         end
         bus.DPRoB_qj = 4'($urandom); bus.DPRoB_qk = 4'($urandom);
         exp_j = 0; exp_k = 0;
         foreach (q[i]) begin
            if (q[i].rdy && q[i].idx == bus.DPRoB_qj) exp_j = {1'b1, q[i].val};
            if (q[i].rdy && q[i].idx == bus.DPRoB_qk) exp_k = {1'b1, q[i].val};
         end
         if (lsb_pos >= 0 && bus.CDBRoB_LSB_RoB_index == bus.DPRoB_qj) exp_j = {1'b1, bus.CDBRoB_LSB_value};
         if (lsb_pos >= 0 && bus.CDBRoB_LSB_RoB_index == bus.DPRoB_qk) exp_k = {1'b1, bus.CDBRoB_LSB_value};
         if (rs_pos >= 0 && bus.CDBRoB_RS_RoB_index == bus.DPRoB_qj) exp_j = {1'b1, bus.CDBRoB_RS_value};
         if (rs_pos >= 0 && bus.CDBRoB_RS_RoB_index == bus.DPRoB_qk) exp_k = {1'b1, bus.CDBRoB_RS_value};
         #1;
         total++;
         if ({bus.RoBDP_qj_ready, exp_j[32] ? bus.RoBDP_qj_value : 32'h0, bus.RoBDP_qk_ready, exp_k[32] ? bus.RoBDP_qk_value : 32'h0} !== {exp_j, exp_k})
            $display("FAIL rand_lookup cyc=%0d got j=%b/%h k=%b/%h want j=%h k=%h", c,
                     bus.RoBDP_qj_ready, bus.RoBDP_qj_value, bus.RoBDP_qk_ready, bus.RoBDP_qk_value, exp_j, exp_k);
         else passed++;
         if (rdy_in) begin
            full = q.size() == 16;
            commit = q.size() > 0 && q[0].rdy;
            if (commit) h = q[0];
            if (!e_clear) begin
               if (rs_pos >= 0) begin
                  q[rs_pos].rdy = 1; q[rs_pos].val = bus.CDBRoB_RS_value; q[rs_pos].npc = bus.CDBRoB_RS_next_pc;
               end
               if (lsb_pos >= 0) begin
                  q[lsb_pos].rdy = 1; q[lsb_pos].val = bus.CDBRoB_LSB_value;
               end
            end
            e_rf_en = 0; e_lsb_en = 0; e_clear = 0; mis = 0;
            if (commit) begin
               void'(q.pop_front());
               if (h.t == 2'd0 || h.t == 2'd3) begin
                  e_rf_en = 1; e_rd = h.rd; e_val = h.val; e_rfi = h.idx;
               end
               if (h.t == 2'd1) begin
                  e_lsb_en = 1; e_lsbi = h.idx;
               end
               if (h.t[1] && h.npc != h.pred) begin
                  mis = 1; e_clear = 1; e_npc = h.npc;
               end
            end
            if (mis) begin
               q.delete();
               m_tail = 0;
            end else if (bus.DPRoB_en && !full) begin
               q.push_back('{t: bus.DPRoB_type, rd: bus.DPRoB_rd, pred: bus.DPRoB_pred_pc, val: 0, npc: 0, rdy: 0, idx: m_tail});
               m_tail++;
            end
         end else begin
            e_rf_en = 0; e_lsb_en = 0; e_clear = 0;
         end
         tick();
         total++;
         if ({bus.RoBRF_en, bus.RoBRF_rd, bus.RoBRF_value, bus.RoBRF_index, bus.RoBLSB_commit_en, bus.RoBLSB_commit_index,
              bus.RoB_clear, bus.RoBIF_new_pc} !== {e_rf_en, e_rd, e_val, e_rfi, e_lsb_en, e_lsbi, e_clear, e_npc})
            $display("FAIL rand_commit cyc=%0d got rf=%b/%0d/%h/%0d lsb=%b/%0d clr=%b/%h want rf=%b/%0d/%h/%0d lsb=%b/%0d clr=%b/%h", c,
                     bus.RoBRF_en, bus.RoBRF_rd, bus.RoBRF_value, bus.RoBRF_index, bus.RoBLSB_commit_en, bus.RoBLSB_commit_index,
                     bus.RoB_clear, bus.RoBIF_new_pc, e_rf_en, e_rd, e_val, e_rfi, e_lsb_en, e_lsbi, e_clear, e_npc);
         else passed++;
         total++;
         if ({bus.RoBDP_tail, bus.RoBDP_full} !== {m_tail, q.size() == 16})
            $display("FAIL rand_ptr cyc=%0d got tail=%0d full=%b want tail=%0d full=%b", c,
                     bus.RoBDP_tail, bus.RoBDP_full, m_tail, q.size() == 16);
         else passed++;
      end
      idle();
      rdy_in = 1;
   endtask

   initial begin
      idle();
      test_reset();
      test_single_commit();
      test_full_wrap();
      test_out_of_order();
      test_forwarding();
      test_mispredict();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
